dds_sweep_ctrl: RTL

DDS_SWEEP_CTRL -- requirements
Module: dds_sweep_ctrl

---
 rtl/dds_sweep_ctrl.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/dds_sweep_ctrl.sv
// dds_sweep_ctrl: frequency sweep controller feeding a DDS tuning word.
// Steps the tuning word from f_start towards f_stop, holding each value for
// 'dwell' sample strobes. Optional up/down triangle sweep when the macro
// DDS_SWEEP_CONT_EN is defined; otherwise mode is ignored and dir is 0.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   sample_ce           sample strobe (shared with DDS ce / I2S tx_rd_en)
//   start, abort        single-cycle sweep start / abort requests
//   mode                0 = single up-sweep, 1 = continuous triangle
//   f_start, f_stop     sweep limits (unsigned tuning words)
//   step, dwell         increment per step, strobes held per value
//   tuning_word         registered tuning word to the DDS
//   busy, done, dir     sweep active, completion pulse, 1 = descending
module dds_sweep_ctrl #(
   parameter int unsigned TW  = 16,
   parameter int unsigned DWW = 16
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           sample_ce,
   input  logic           start,
   input  logic           abort,
   input  logic           mode,
   input  logic [TW-1:0]  f_start,
   input  logic [TW-1:0]  f_stop,
   input  logic [TW-1:0]  step,
   input  logic [DWW-1:0] dwell,
   output logic [TW-1:0]  tuning_word,
   output logic           busy,
   output logic           done,
   output logic           dir
);

`ifdef DDS_SWEEP_CONT_EN
   typedef enum logic [1:0] {IDLE = 2'd0, UP = 2'd1, DOWN = 2'd2} state_e;
`else
   typedef enum logic [1:0] {IDLE = 2'd0, UP = 2'd1} state_e;
`endif

   state_e          state_q, state_d;
   logic [TW-1:0]   tw_q, tw_d;
   logic [DWW-1:0]  cnt_q, cnt_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic [TW-1:0]   f_start_q, f_start_d;
   logic [TW-1:0]   f_stop_q, f_stop_d;
   logic [TW-1:0]   step_q, step_d;
   logic [DWW-1:0]  dwell_q, dwell_d;
   logic [DWW-1:0]  cnt_inc;
   logic            dwell_hit;
   logic [TW:0]     up_sum;
`ifdef DDS_SWEEP_CONT_EN
   logic            mode_q, mode_d;
   logic            dir_q, dir_d;
   logic [TW:0]     dn_diff;
`else
   logic            unused_mode;
   assign unused_mode = mode;
`endif

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         tw_q      <= '0;
         cnt_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         f_start_q <= '0;
         f_stop_q  <= '0;
         step_q    <= '0;
         dwell_q   <= '0;
`ifdef DDS_SWEEP_CONT_EN
         mode_q    <= 1'b0;
         dir_q     <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         tw_q      <= tw_d;
         cnt_q     <= cnt_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         f_start_q <= f_start_d;
         f_stop_q  <= f_stop_d;
         step_q    <= step_d;
         dwell_q   <= dwell_d;
`ifdef DDS_SWEEP_CONT_EN
         mode_q    <= mode_d;
         dir_q     <= dir_d;
`endif
      end
   end

   // Next-state and datapath logic
   always_comb begin
      state_d   = state_q;
      tw_d      = tw_q;
      cnt_d     = cnt_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      f_start_d = f_start_q;
      f_stop_d  = f_stop_q;
      step_d    = step_q;
      dwell_d   = dwell_q;
`ifdef DDS_SWEEP_CONT_EN
      mode_d    = mode_q;
      dir_d     = dir_q;
      dn_diff   = {1'b0, tw_q} - {1'b0, step_q};
`endif
      cnt_inc   = cnt_q + DWW'(1);
      dwell_hit = (cnt_inc == dwell_q);
      up_sum    = {1'b0, tw_q} + {1'b0, step_q};

      unique case (state_q)
         IDLE: begin
            // abort wins over a coincident start, which then does nothing
            if (start && !abort) begin
               f_start_d = f_start;
               f_stop_d  = f_stop;
               step_d    = (step == '0) ? TW'(1) : step;
               dwell_d   = (dwell == '0) ? DWW'(1) : dwell;
`ifdef DDS_SWEEP_CONT_EN
               // a degenerate range finishes after one dwell, so never turns
               mode_d    = mode && (f_start < f_stop);
               dir_d     = 1'b0;
`endif
               tw_d      = f_start;
               cnt_d     = '0;
               busy_d    = 1'b1;
               state_d   = UP;
            end
         end
         UP: begin
            if (abort) begin
               state_d = IDLE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               cnt_d   = '0;
            end else if (sample_ce) begin
               if (!dwell_hit) begin
                  cnt_d = cnt_inc;
               end else begin
                  cnt_d = '0;
                  if (tw_q >= f_stop_q) begin
`ifdef DDS_SWEEP_CONT_EN
                     if (mode_q) begin
                        state_d = DOWN;
                        dir_d   = 1'b1;
                     end else begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                     end
`else
                     state_d = IDLE;
                     busy_d  = 1'b0;
                     done_d  = 1'b1;
`endif
                  end else if (up_sum >= {1'b0, f_stop_q}) begin
                     tw_d = f_stop_q;
                  end else begin
                     tw_d = up_sum[TW-1:0];
                  end
               end
            end
         end
`ifdef DDS_SWEEP_CONT_EN
         DOWN: begin
            if (abort) begin
               state_d = IDLE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               dir_d   = 1'b0;
               cnt_d   = '0;
            end else if (sample_ce) begin
               if (!dwell_hit) begin
                  cnt_d = cnt_inc;
               end else begin
                  cnt_d = '0;
                  if (tw_q <= f_start_q) begin
                     // turn-around holds the word; no advance on this expiry
                     state_d = UP;
                     dir_d   = 1'b0;
                  end else if ($signed(dn_diff) <= $signed({1'b0, f_start_q})) begin
                     tw_d = f_start_q;
                  end else begin
                     tw_d = dn_diff[TW-1:0];
                  end
               end
            end
         end
`endif
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   assign tuning_word = tw_q;
   assign busy        = busy_q;
   assign done        = done_q;
`ifdef DDS_SWEEP_CONT_EN
   assign dir         = dir_q;
`else
   assign dir         = 1'b0;
`endif

endmodule
